// File: rtl/clip_pkg.sv
// Shared types, mode/block constants and rate helpers for the clip timer sequencer.
package clip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic BLK_0 = 1'b0;
    localparam logic BLK_1 = 1'b1;

    function automatic int unsigned clip_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

    function automatic int unsigned clip_samples(input int unsigned sample_hz,
                                                 input int unsigned seconds);
        return sample_hz * seconds;
    endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Divide-by-DIV counter: tick_o is high on cycles where the count sits at DIV-1.
// tick_next_c previews tick_o one cycle early so callers can register aligned strobes.
module sample_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o,
    output logic tick_next_c
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == CNT_W'(DIV - 1)) ? '0 : count_q + CNT_W'(1);
        end
        tick_next_c = (count_d == CNT_W'(DIV - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_next_c;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/clip_timer_sequencer.sv
// Paces one fixed-length audio clip per timer enable and drives clip RAM strobes.
// Optional per-block recorded-length tracking: define CLIP_LEN_TRACK_EN.
module clip_timer_sequencer
    import clip_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SAMPLE_HZ    = 8_000,
    parameter int unsigned CLIP_SECONDS = 2,
    parameter int unsigned IDX_W        = $clog2(clip_samples(SAMPLE_HZ, CLIP_SECONDS))
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             timer,
    input  logic [1:0]       memoryselect_clip_1,
    output logic             seconds2,
    output logic             sample_tick,
    output logic [IDX_W:0]   mem_addr,
    output logic             mem_we,
    output logic             mem_re,
    output logic             busy
);

    localparam int unsigned DIV     = clip_div(CLK_HZ, SAMPLE_HZ);
    localparam int unsigned SAMPLES = clip_samples(SAMPLE_HZ, CLIP_SECONDS);
    localparam int unsigned AW      = IDX_W + 1;

    state_e           state_q, state_d;
    logic             blk_q, blk_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [AW-1:0]    issued_c, limit_c;
    logic             tick_c, tick_next_c;
    logic             strobe_d;
    logic             seconds2_q, seconds2_d;
    logic             sample_tick_q;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_re_q, busy_q;

    sample_prescaler #(.DIV(DIV)) u_prescaler (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     (state_q != RUN),
        .en_i        (state_q == RUN),
        .tick_o      (tick_c),
        .tick_next_c (tick_next_c)
    );

    // Strobes issued so far including the one on this cycle, if any.
    assign issued_c = AW'(idx_q) + AW'(tick_c);

`ifdef CLIP_LEN_TRACK_EN
    logic [AW-1:0] len_q [2];
    logic          len_we_c;

    assign len_we_c = (state_q == RUN) && (wr_q == MODE_WRITE) && (state_d != RUN);
    assign limit_c  = (wr_q == MODE_WRITE) ? AW'(SAMPLES) : len_q[blk_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else if (len_we_c) begin
            len_q[blk_q] <= issued_c;
        end
    end
`else
    assign limit_c = AW'(SAMPLES);
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (timer) begin
                    blk_d   = memoryselect_clip_1[1] ? BLK_1 : BLK_0;
                    wr_d    = memoryselect_clip_1[0] ? MODE_WRITE : MODE_READ;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef CLIP_LEN_TRACK_EN
                    // Nothing recorded in this block: complete immediately.
                    if ((wr_d == MODE_READ) && (len_q[blk_d] == '0)) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (tick_c) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (!timer) begin
                    state_d = IDLE;
                end else if (tick_c && (issued_c == limit_c)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!timer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output next values, registered so strobe and address land together.
        strobe_d   = (state_d == RUN) && tick_next_c;
        seconds2_d = (state_d == DONE) && (state_q != DONE);
        mem_addr_d = strobe_d ? {blk_d, idx_d} : mem_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            blk_q         <= BLK_0;
            wr_q          <= MODE_READ;
            idx_q         <= '0;
            seconds2_q    <= 1'b0;
            sample_tick_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            wr_q          <= wr_d;
            idx_q         <= idx_d;
            seconds2_q    <= seconds2_d;
            sample_tick_q <= strobe_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= strobe_d && (wr_d == MODE_WRITE);
            mem_re_q      <= strobe_d && (wr_d == MODE_READ);
            busy_q        <= (state_d == RUN);
        end
    end

    assign seconds2    = seconds2_q;
    assign sample_tick = sample_tick_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_clip_timer_sequencer.sv
// Directed scoreboard bench: expected strobes are queued per clip and matched as the DUT emits them.
module tb_clip_timer_sequencer;

    localparam int AW = 6;

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        int            rc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          timer;
    logic [1:0]    msel;
    logic          seconds2;
    logic          sample_tick;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic          busy;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   rc       = 0;
    int   s2_cnt   = 0;
    int   s2_rc    = 0;
    int   busy_cnt = 0;
    int   n_rd     = 0;

    clip_timer_sequencer #(
        .CLK_HZ       (40),
        .SAMPLE_HZ    (10),
        .CLIP_SECONDS (2)
    ) dut (
        .clock               (clk),
        .reset               (reset),
        .timer               (timer),
        .memoryselect_clip_1 (msel),
        .seconds2            (seconds2),
        .sample_tick         (sample_tick),
        .mem_addr            (mem_addr),
        .mem_we              (mem_we),
        .mem_re              (mem_re),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected strobes for n samples of one block; tick k lands on run cycle 4*(k+1).
    task automatic push_clip(input logic we, input int blk, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.we   = we;
            e.re   = ~we;
            e.addr = AW'(blk * 32 + k);
            e.rc   = 4 * (k + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_clip();
        rc       = 0;
        s2_cnt   = 0;
        s2_rc    = 0;
        busy_cnt = 0;
    endtask

    // Advance one cycle, sample after the edge, and score any strobe.
    task automatic tick_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        rc++;
        if (busy) busy_cnt++;
        if (seconds2) begin
            s2_cnt++;
            s2_rc = rc;
        end
        check("tick_vs_strobe", 32'(sample_tick), 32'(mem_we | mem_re));
        if (mem_we || mem_re) begin
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 32'({mem_we, mem_re}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_we", 32'(mem_we), 32'(e.we));
                check("strobe_re", 32'(mem_re), 32'(e.re));
                check("strobe_addr", 32'(mem_addr), 32'(e.addr));
                check("strobe_cycle", 32'(rc), 32'(e.rc));
            end
        end
    endtask

    task automatic end_clip();
        timer = 1'b0;
        tick_cycle();
        tick_cycle();
    endtask

    initial begin
        reset = 1'b1;
        timer = 1'b1;
        msel  = 2'b01;

        // Reset dominates a simultaneous timer request.
        for (int i = 0; i < 3; i++) begin
            tick_cycle();
            check("reset_outputs", 32'({seconds2, sample_tick, mem_addr, mem_we, mem_re, busy}), 32'd0);
        end

        // Full write clip to block 0.
        reset = 1'b0;
        start_clip();
        push_clip(1'b1, 0, 20);
        repeat (90) tick_cycle();
        check("w0_pending", 32'(exp_q.size()), 32'd0);
        check("w0_s2_count", 32'(s2_cnt), 32'd1);
        check("w0_s2_cycle", 32'(s2_rc), 32'd81);
        check("w0_busy_len", 32'(busy_cnt), 32'd80);
        end_clip();

        // Read block 1 with timer held high after completion.
        msel  = 2'b10;
        timer = 1'b1;
        start_clip();
`ifdef CLIP_LEN_TRACK_EN
        repeat (100) tick_cycle();
        check("r1_s2_cycle", 32'(s2_rc), 32'd1);
        check("r1_busy_len", 32'(busy_cnt), 32'd0);
`else
        push_clip(1'b0, 1, 20);
        repeat (100) tick_cycle();
        check("r1_s2_cycle", 32'(s2_rc), 32'd81);
        check("r1_busy_len", 32'(busy_cnt), 32'd80);
`endif
        check("r1_pending", 32'(exp_q.size()), 32'd0);
        check("r1_s2_count", 32'(s2_cnt), 32'd1);
        check("r1_held_idle", 32'(busy), 32'd0);
        timer = 1'b0;
        tick_cycle();
        timer = 1'b1;
        tick_cycle();
`ifdef CLIP_LEN_TRACK_EN
        check("r1_retrigger_s2", 32'(seconds2), 32'd1);
`else
        check("r1_retrigger_busy", 32'(busy), 32'd1);
`endif
        end_clip();

        // Write block 0 aborted after 10 strobes.
        msel  = 2'b01;
        timer = 1'b1;
        start_clip();
        push_clip(1'b1, 0, 10);
        repeat (40) tick_cycle();
        timer = 1'b0;
        repeat (20) tick_cycle();
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        check("abort_s2_count", 32'(s2_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        // Read block 0 back.
`ifdef CLIP_LEN_TRACK_EN
        n_rd = 10;
`else
        n_rd = 20;
`endif
        msel  = 2'b00;
        timer = 1'b1;
        start_clip();
        push_clip(1'b0, 0, n_rd);
        repeat (4 * n_rd + 10) tick_cycle();
        check("r0_pending", 32'(exp_q.size()), 32'd0);
        check("r0_s2_count", 32'(s2_cnt), 32'd1);
        check("r0_s2_cycle", 32'(s2_rc), 32'(4 * n_rd + 1));
        end_clip();

        // Mode select changes mid-run are ignored.
        msel  = 2'b01;
        timer = 1'b1;
        start_clip();
        push_clip(1'b1, 0, 20);
        repeat (30) tick_cycle();
        check("addr_hold", 32'(mem_addr), 32'd6);
        msel = 2'b00;
        repeat (60) tick_cycle();
        check("msel_pending", 32'(exp_q.size()), 32'd0);
        check("msel_s2_cycle", 32'(s2_rc), 32'd81);
        end_clip();

        // Reset at run cycle 40 aborts silently; next clip restarts at idx 0.
        msel  = 2'b01;
        timer = 1'b1;
        start_clip();
        push_clip(1'b1, 0, 10);
        repeat (40) tick_cycle();
        reset = 1'b1;
        tick_cycle();
        check("midrst_outputs", 32'({seconds2, sample_tick, mem_addr, mem_we, mem_re, busy}), 32'd0);
        tick_cycle();
        check("midrst_s2_count", 32'(s2_cnt), 32'd0);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        start_clip();
        push_clip(1'b1, 0, 20);
        repeat (90) tick_cycle();
        check("fresh_pending", 32'(exp_q.size()), 32'd0);
        check("fresh_s2_cycle", 32'(s2_rc), 32'd81);
        check("fresh_busy_len", 32'(busy_cnt), 32'd80);
        end_clip();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clip_timer_sequencer.md
Name: clip_timer_sequencer

Overview:
- Responder side of the controller's timer/memory-select interface.
- Takes the controller's `timer` enable and `memoryselect_clip_1` (block, read/write), paces a fixed-length clip at the audio sample rate, and drives per-sample memory strobes and addresses.
- Returns the `seconds2` completion pulse to the controller.
- Sits between the controller and the clip RAM / audio sample path.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SAMPLE_HZ, 8_000, sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer, DIV >= 2).
- CLIP_SECONDS, 2, clip duration; SAMPLES = SAMPLE_HZ*CLIP_SECONDS.
- IDX_W, $clog2(SAMPLES), sample index width; address width = IDX_W+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- timer  in  1  level enable from controller; 1 = run a clip.
- memoryselect_clip_1  in  2  [1] = block (0/1); [0] = 1 write (record), 0 read (play).
- seconds2  out  1  one-cycle pulse: full clip elapsed.
- sample_tick  out  1  one-cycle pulse per sample period while running.
- mem_addr  out  IDX_W+1  {block, sample_idx}.
- mem_we  out  1  write strobe, equals sample_tick in write mode.
- mem_re  out  1  read strobe, equals sample_tick in read mode.
- busy  out  1  high in RUN.

Behaviour:
- Reset (synchronous, dominant over every other input) forces the following. Mid-run reset aborts with no `seconds2` pulse.
  - State = IDLE.
  - All outputs 0.
  - Prescaler = 0, sample_idx = 0, latched block/mode = 0.
- States: IDLE, RUN, DONE.
- IDLE, when `timer` = 1:
  - Latch `memoryselect_clip_1` into blk/wr.
  - Clear prescaler and idx.
  - Next state RUN.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - When prescaler = DIV-1, `sample_tick` = 1 that cycle, so the first tick is on the DIV-th cycle in RUN.
  - On a tick, `mem_addr` = {blk, idx}; `mem_we` = wr, `mem_re` = !wr.
  - idx increments after the tick cycle.
  - Outputs are registered, so strobe and address are valid on the same cycle.
  - `mem_addr` holds its last value between ticks.
- RUN to DONE: on the tick where idx = SAMPLES-1. The tick with idx SAMPLES-1 is still issued.
- DONE:
  - `seconds2` = 1 for exactly one cycle, the first cycle in DONE.
  - Remain in DONE until `timer` = 0, then go to IDLE. This prevents retrigger while the controller holds enable.
- RUN with `timer` = 0: abort to IDLE next cycle, no `seconds2`, no further strobes. If an abort coincides with the final tick, the abort wins: the final strobe is still issued but there is no `seconds2`.
- `memoryselect_clip_1` changes during RUN/DONE are ignored; the latched value governs the whole clip.
- `busy` = 1 exactly while state = RUN.
- Total RUN length = SAMPLES*DIV cycles.

Optional Feature:
- Macro: CLIP_LEN_TRACK_EN.
- With the macro defined:
  - Per-block length registers len[0..1] (IDX_W+1 bits), reset to 0.
  - A write clip that completes stores SAMPLES.
  - A write clip aborted by `timer` = 0 stores the number of strobes issued.
  - A read clip ends at len[blk] samples instead of SAMPLES, and `seconds2` still pulses.
  - A read of a block with len = 0 goes IDLE to DONE in one cycle, with no strobes and `seconds2` pulsing.
- Without the macro: fixed SAMPLES-length clips for both modes; no length registers.

Decomposition:
- Shared package (clip_pkg):
  - State enum {IDLE, RUN, DONE}.
  - Mode constants MODE_READ = 1'b0, MODE_WRITE = 1'b1.
  - Block index constants.
  - Helper function computing DIV and SAMPLES.
- One natural sub-module: sample_prescaler.
  - Parameterised DIV counter.
  - Inputs: clear, enable. Output: tick.
  - Reused by the audio sampler.

Test Plan (CLK_HZ=40, SAMPLE_HZ=10, CLIP_SECONDS=2 → DIV=4, SAMPLES=20, IDX_W=5):
- Reset held 3 cycles, then `timer` = 1 in the same cycle as reset → all outputs 0 while reset is high; RUN is entered only on the first cycle after reset drops.
- `timer` = 1, msel = 2'b01 (block 0, write) →
  - `mem_we` pulses on RUN cycles 4, 8, …, 80 with `mem_addr` 0..19.
  - `mem_re` stays 0.
  - `seconds2` is high only on cycle 81.
  - `busy` stays high for 80 cycles.
- msel = 2'b10 (block 1, read), `timer` held high after done → `mem_re` at addresses 32..51, one `seconds2` pulse, no retrigger until `timer` goes 0 and then 1.
- Write block 0, drop `timer` after 10 strobes → IDLE with no `seconds2`. With CLIP_LEN_TRACK_EN, a subsequent read of block 0 gives exactly 10 strobes (addresses 0..9), then `seconds2`.
- Toggle msel from 2'b01 to 2'b00 mid-run → the strobe type stays `mem_we` and the block stays 0 for the whole clip.
- Reset asserted at RUN cycle 40 → outputs 0 the next cycle, no `seconds2`; a fresh clip after reset starts at idx 0.
